// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: the opcode map, the control
// states of the request/response handshake and the bit positions of the
// five status flags.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_ADD    = 4'd1,
        OP_SUB    = 4'd2,
        OP_MULT   = 4'd3,
        OP_SHR    = 4'd4,
        OP_DIV    = 4'd5,
        OP_AND    = 4'd6,
        OP_OR     = 4'd7,
        OP_XOR    = 4'd8,
        OP_SHL    = 4'd9,
        OP_PASSB0 = 4'd10,
        OP_PASSB1 = 4'd11,
        OP_PASSB2 = 4'd12,
        OP_PASSA  = 4'd13,
        OP_PASSB3 = 4'd14,
        OP_HALT   = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;
    localparam int FLAG_DIV0  = 4;
    localparam int FLAG_W     = 5;

    // Multiply and divide run on the iterative unit; everything else is
    // resolved in a single cycle.
    function automatic logic isIterOp(input opcode_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier / restoring divider.  Operands are captured
// on start, one bit is processed per cycle, and done is high during the last
// iteration cycle so the final value is visible in the registers right after
// that edge.  The result registers hold their value until the next start.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             hi_nonzero,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH);

    // hi holds the upper product half (MULT) or the partial remainder (DIV);
    // lo holds the multiplier shifting out / the dividend shifting out while
    // the quotient shifts in; opnd is the multiplicand or divisor.
    logic             busy_q;
    logic             isDiv_q;
    logic             divZero_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divTrial;
    logic [WIDTH:0]   divDiff;

    // One shift-add or one restore-subtract step on the working registers.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        divTrial = {hi_q, lo_q[WIDTH-1]};
        divDiff  = divTrial - {1'b0, opnd_q};
        if (isDiv_q) begin
            if (!divDiff[WIDTH]) begin
                hi_d = divDiff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = divTrial[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            {hi_d, lo_d} = {mulSum, lo_q[WIDTH-1:1]};
        end
    end

    // Capture operands on start, then iterate exactly WIDTH times.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            isDiv_q   <= 1'b0;
            divZero_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
        end else if (start) begin
            busy_q    <= 1'b1;
            isDiv_q   <= is_div;
            divZero_q <= (b == '0);
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= a;
            opnd_q    <= b;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done       = busy_q && (cnt_q == CW'(WIDTH - 1));
    // A zero divisor still runs the full iteration count; only the visible
    // quotient is forced to all-ones.
    assign res        = (isDiv_q && divZero_q) ? '1 : lo_q;
    assign hi_nonzero = !isDiv_q && (hi_q != '0);
    assign div0       = isDiv_q && divZero_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready request port and a valid/ready result
// port.  Single-cycle operations land in the result register on the accept
// edge; MULT and DIV are handed to the iterative unit and their result is
// read straight from its held registers once it finishes.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [WIDTH-1:0]  operand0,
    input  logic [WIDTH-1:0]  operand1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    res_q;
    logic [FLAG_W-1:0]   flags_q;
    logic                iterSel_q;

    opcode_e             opDec;
    logic                accept;
    logic                isIter;
    logic [WIDTH:0]      aluSum;
    logic [WIDTH-1:0]    aluRes;
    logic                aluCarry;
    logic                aluOvf;
    logic [FLAG_W-1:0]   aluFlags;
    logic                mdDone;
    logic [WIDTH-1:0]    mdRes;
    logic                mdHi;
    logic                mdDiv0;
    logic [FLAG_W-1:0]   mdFlags;

    assign opDec     = opcode_e'(opcode);
    assign isIter    = isIterOp(opDec);
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept && isIter),
        .is_div     (opDec == OP_DIV),
        .a          (operand0),
        .b          (operand1),
        .done       (mdDone),
        .res        (mdRes),
        .hi_nonzero (mdHi),
        .div0       (mdDiv0)
    );

    // Single-cycle datapath: result plus carry/overflow for the current request.
    always_comb begin
        aluSum   = '0;
        aluRes   = '0;
        aluCarry = 1'b0;
        aluOvf   = 1'b0;
        aluFlags = '0;
        case (opDec)
            OP_NOP, OP_PASSA: aluRes = operand0;
            OP_ADD: begin
                aluSum   = {1'b0, operand0} + {1'b0, operand1};
                aluRes   = aluSum[WIDTH-1:0];
                aluCarry = aluSum[WIDTH];
                aluOvf   = (operand0[WIDTH-1] == operand1[WIDTH-1]) &&
                           (aluSum[WIDTH-1] != operand0[WIDTH-1]);
            end
            OP_SUB: begin
                aluSum   = {1'b0, operand0} - {1'b0, operand1};
                aluRes   = aluSum[WIDTH-1:0];
                aluCarry = aluSum[WIDTH];
                aluOvf   = (operand0[WIDTH-1] != operand1[WIDTH-1]) &&
                           (aluSum[WIDTH-1] != operand0[WIDTH-1]);
            end
            OP_SHR: begin
                aluRes   = operand1 >> 1;
                aluCarry = operand1[0];
            end
            OP_SHL: begin
                aluRes   = operand1 << 1;
                aluCarry = operand1[WIDTH-1];
            end
            OP_AND: aluRes = operand0 & operand1;
            OP_OR:  aluRes = operand0 | operand1;
            OP_XOR: aluRes = operand0 ^ operand1;
            OP_PASSB0, OP_PASSB1, OP_PASSB2, OP_PASSB3: aluRes = operand1;
            default: aluRes = '0;
        endcase
        aluFlags[FLAG_ZERO]  = (aluRes == '0);
        aluFlags[FLAG_NEG]   = aluRes[WIDTH-1];
        aluFlags[FLAG_CARRY] = aluCarry;
        aluFlags[FLAG_OVF]   = aluOvf;
    end

    // Flags for a MULT/DIV result, derived from the iterative unit's outputs.
    always_comb begin
        mdFlags              = '0;
        mdFlags[FLAG_ZERO]   = (mdRes == '0);
        mdFlags[FLAG_NEG]    = mdRes[WIDTH-1];
        mdFlags[FLAG_CARRY]  = mdHi;
        mdFlags[FLAG_OVF]    = mdHi;
        mdFlags[FLAG_DIV0]   = mdDiv0;
    end

    // Handshake control: accept only in IDLE, present only in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = isIter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (mdDone)   state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, single-cycle result capture and the result source select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            res_q     <= '0;
            flags_q   <= '0;
            iterSel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                iterSel_q <= isIter;
                if (!isIter) begin
                    res_q   <= aluRes;
                    flags_q <= aluFlags;
                end
            end
        end
    end

    assign result = iterSel_q ? mdRes   : res_q;
    assign flags  = iterSel_q ? mdFlags : flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a WIDTH=16 instance exercised with directed and random
// requests, and a WIDTH=8 instance for the narrow-width checks.  Expected
// results come from a plain-arithmetic model of the operation table.
module tb_alu_seq;

    localparam int W  = 16;
    localparam int W8 = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [3:0]    opcode;
    logic [W-1:0]  operand0, operand1, result;
    logic [4:0]    flags;
    logic          in_valid8, in_ready8, out_valid8, out_ready8;
    logic [3:0]    opcode8;
    logic [W8-1:0] operand08, operand18, result8;
    logic [4:0]    flags8;

    int nChecks = 0;
    int nFails  = 0;

    logic [3:0]  dOp   [7] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd5, 4'd5};
    logic [15:0] dA    [7] = '{16'h7FFF, 16'd3, 16'd5, 16'h0100, 16'd7, 16'd100, 16'd5};
    logic [15:0] dB    [7] = '{16'h0001, 16'd5, 16'd5, 16'h0100, 16'd6, 16'd7, 16'd0};
    logic [15:0] dRes  [7] = '{16'h8000, 16'hFFFE, 16'h0000, 16'h0000, 16'd42, 16'd14, 16'hFFFF};
    logic [4:0]  dFlg  [7] = '{5'b01010, 5'b00110, 5'b00001, 5'b01101, 5'b00000, 5'b00000, 5'b10010};
    int          dLat  [7] = '{1, 1, 1, 17, 17, 17, 17};

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand0(operand0), .operand1(operand1),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    alu_seq #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .opcode(opcode8), .operand0(operand08), .operand1(operand18),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .flags(flags8)
    );

    // Reference: the operation table evaluated with ordinary integer arithmetic.
    function automatic void refModel(input int w, input int op,
                                     input longint unsigned a, input longint unsigned b,
                                     output longint unsigned r, output logic [4:0] f);
        longint unsigned mask = (64'd1 << w) - 1;
        longint sa, sb, s;
        longint smax = (longint'(1) << (w - 1)) - 1;
        longint smin = -(longint'(1) << (w - 1));
        longint unsigned full;
        logic dz, ov, cy;
        dz = 0; ov = 0; cy = 0; r = 0;
        sa = (a > longint'(smax)) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = (b > longint'(smax)) ? longint'(b) - (longint'(1) << w) : longint'(b);
        case (op)
            0, 13: r = a;
            1: begin r = (a + b) & mask; cy = ((a + b) >> w) != 0; s = sa + sb; ov = (s > smax) || (s < smin); end
            2: begin r = (a - b) & mask; cy = a < b; s = sa - sb; ov = (s > smax) || (s < smin); end
            3: begin full = a * b; r = full & mask; cy = (full >> w) != 0; ov = cy; end
            4: begin r = b >> 1; cy = (b & 1) != 0; end
            5: begin if (b == 0) begin r = mask; dz = 1; end else r = a / b; end
            6: r = a & b;
            7: r = a | b;
            8: r = a ^ b;
            9: begin r = (b << 1) & mask; cy = ((b >> (w - 1)) & 1) != 0; end
            15: r = 0;
            default: r = b;
        endcase
        f = {dz, ov, cy, ((r >> (w - 1)) & 1) != 0, r == 0};
    endfunction

    function automatic logic [15:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Issue one request on the 16-bit instance and collect its response.
    // lat counts cycles from the accept edge to out_valid; -1 means timeout.
    task automatic runOp16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic [4:0] f, output int lat);
        int waitCnt = 0;
        while (!in_ready && waitCnt < 200) begin @(posedge clk); #1; waitCnt++; end
        opcode = op; operand0 = a; operand1 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; opcode = 4'($urandom); operand0 = 16'($urandom); operand1 = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid) lat = -1;
        r = result; f = flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic runOp8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic [4:0] f, output int lat);
        int waitCnt = 0;
        while (!in_ready8 && waitCnt < 200) begin @(posedge clk); #1; waitCnt++; end
        opcode8 = op; operand08 = a; operand18 = b; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; opcode8 = 4'($urandom); operand08 = 8'($urandom); operand18 = 8'($urandom);
        lat = 1;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid8) lat = -1;
        r = result8; f = flags8;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; opcode = '0; operand0 = '0; operand1 = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; opcode8 = '0; operand08 = '0; operand18 = '0;
        repeat (3) @(posedge clk);
        #1;
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        nChecks++; if (result !== 16'h0) begin nFails++; $display("[TB] FAIL reset_result: got %h expected 0000", result); end
        nChecks++; if (flags !== 5'b0) begin nFails++; $display("[TB] FAIL reset_flags: got %b expected 00000", flags); end
        nChecks++; if (out_valid8 !== 1'b0 || result8 !== 8'h0 || flags8 !== 5'b0) begin
            nFails++; $display("[TB] FAIL reset_w8: got valid=%b result=%h flags=%b expected 0/00/00000", out_valid8, result8, flags8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [15:0] r; logic [4:0] f; int lat;
        for (int i = 0; i < 7; i++) begin
            runOp16(dOp[i], dA[i], dB[i], r, f, lat);
            nChecks++; if (r !== dRes[i]) begin nFails++; $display("[TB] FAIL directed_result[%0d]: got %h expected %h", i, r, dRes[i]); end
            nChecks++; if (f !== dFlg[i]) begin nFails++; $display("[TB] FAIL directed_flags[%0d]: got %b expected %b", i, f, dFlg[i]); end
            nChecks++; if (lat != dLat[i]) begin nFails++; $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, dLat[i]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] r, a, b; logic [4:0] f, ef; logic [3:0] op;
        longint unsigned er; int lat, elat;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15)); a = pickOperand(); b = pickOperand();
            runOp16(op, a, b, r, f, lat);
            refModel(W, int'(op), longint'(a), longint'(b), er, ef);
            elat = (op == 4'd3 || op == 4'd5) ? W + 1 : 1;
            nChecks++; if (r !== 16'(er)) begin nFails++; $display("[TB] FAIL random_result op=%0d a=%h b=%h: got %h expected %h", op, a, b, r, 16'(er)); end
            nChecks++; if (f !== ef) begin nFails++; $display("[TB] FAIL random_flags op=%0d a=%h b=%h: got %b expected %b", op, a, b, f, ef); end
            nChecks++; if (lat != elat) begin nFails++; $display("[TB] FAIL random_latency op=%0d: got %0d expected %0d", op, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        longint unsigned er; logic [4:0] ef; int lat = 1; int extra = 0;
        refModel(W, 3, 64'h1234, 64'h0011, er, ef);
        opcode = 4'd3; operand0 = 16'h1234; operand1 = 16'h0011; in_valid = 1'b1;
        @(posedge clk); #1;
        while (!out_valid && lat < 100) begin
            in_valid = ~in_valid; opcode = 4'd1; operand0 = 16'($urandom); operand1 = 16'($urandom);
            @(posedge clk); #1; lat++;
        end
        nChecks++; if (lat != W + 1) begin nFails++; $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, W + 1); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'($urandom); opcode = 4'($urandom); operand0 = 16'($urandom);
            @(posedge clk); #1;
            nChecks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'(er) || flags !== ef) begin
                nFails++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b ready=%b result=%h flags=%b expected 1/0/%h/%b",
                         c, out_valid, in_ready, result, flags, 16'(er), ef);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        nChecks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nFails++; $display("[TB] FAIL bp_handoff: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        repeat (3) begin @(posedge clk); #1; if (out_valid) extra++; end
        nChecks++; if (extra != 0) begin nFails++; $display("[TB] FAIL bp_phantom: got %0d extra out_valid cycles expected 0", extra); end
    endtask

    task automatic test_reset_mid_mult();
        logic [15:0] r; logic [4:0] f; int lat; int pulses = 0;
        opcode = 4'd3; operand0 = 16'h00FF; operand1 = 16'h0101; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; if (out_valid) pulses++; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nChecks++; if (in_ready !== 1'b1 || result !== 16'h0 || flags !== 5'b0) begin
            nFails++; $display("[TB] FAIL abort_state: got ready=%b result=%h flags=%b expected 1/0000/00000", in_ready, result, flags);
        end
        repeat (25) begin @(posedge clk); #1; if (out_valid) pulses++; end
        nChecks++; if (pulses != 0) begin nFails++; $display("[TB] FAIL abort_no_valid: got %0d out_valid cycles expected 0", pulses); end
        runOp16(4'd1, 16'd2, 16'd3, r, f, lat);
        nChecks++; if (r !== 16'd5 || f !== 5'b0 || lat != 1) begin
            nFails++; $display("[TB] FAIL abort_next_add: got result=%h flags=%b lat=%0d expected 0005/00000/1", r, f, lat);
        end
    endtask

    task automatic test_back_to_back();
        int ovCount = 0; int bad = 0;
        opcode = 4'd1; operand0 = 16'h1111; operand1 = 16'h2222; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                ovCount++;
                if (result !== 16'h3333 || in_ready !== 1'b0) bad++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        nChecks++; if (ovCount != 6) begin nFails++; $display("[TB] FAIL b2b_count: got %0d results expected 6", ovCount); end
        nChecks++; if (bad != 0) begin nFails++; $display("[TB] FAIL b2b_data: got %0d bad result cycles expected 0", bad); end
    endtask

    task automatic test_width8();
        logic [7:0] r, a, b; logic [4:0] f, ef; logic [3:0] op;
        longint unsigned er; int lat, elat;
        runOp8(4'd1, 8'h7F, 8'h01, r, f, lat);
        nChecks++; if (r !== 8'h80 || f !== 5'b01010 || lat != 1) begin
            nFails++; $display("[TB] FAIL w8_add: got result=%h flags=%b lat=%0d expected 80/01010/1", r, f, lat);
        end
        runOp8(4'd3, 8'h13, 8'h0B, r, f, lat);
        nChecks++; if (r !== 8'hD1 || f !== 5'b00010 || lat != W8 + 1) begin
            nFails++; $display("[TB] FAIL w8_mult: got result=%h flags=%b lat=%0d expected d1/00010/9", r, f, lat);
        end
        for (int i = 0; i < 20; i++) begin
            op = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom);
            if (i % 5 == 0) b = 8'h00;
            runOp8(op, a, b, r, f, lat);
            refModel(W8, int'(op), longint'(a), longint'(b), er, ef);
            elat = (op == 4'd3 || op == 4'd5) ? W8 + 1 : 1;
            nChecks++;
            if (r !== 8'(er) || f !== ef || lat != elat) begin
                nFails++;
                $display("[TB] FAIL w8_random op=%0d a=%h b=%h: got %h/%b/%0d expected %h/%b/%0d", op, a, b, r, f, lat, 8'(er), ef, elat);
            end
        end
    endtask

    initial begin
        $display("[TB] starting alu_seq bench");
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_mult();
        test_back_to_back();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
